// File: rtl/tug_input_ctrl.sv
// Tug-of-war input conditioner: sync + debounce raw keys into one-cycle L/R move pulses.
// Press-to-pulse latency is DEBOUNCE_CYCLES+1 edges after the key is sampled; freeze masks pulses only.
// `define CPU_PLAYER_EN to replace the right key with an LFSR-driven computer player.
module tug_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l_n,
  input  logic       key_r_n,
  input  logic       freeze,
  input  logic [8:0] cpu_speed,
  output logic       L,
  output logic       R
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef CPU_PLAYER_EN
  localparam int NK = 1;
`else
  localparam int NK = 2;
`endif

  logic [NK-1:0] key_n;
  logic [NK-1:0] s1;
  logic [NK-1:0] s2;
  logic [NK-1:0] deb;
  logic [NK-1:0] press;
  logic [CW-1:0] cnt [NK];

`ifdef CPU_PLAYER_EN
  assign key_n = key_l_n;
`else
  assign key_n = {key_r_n, key_l_n};
`endif

  // Index 0 is the left key; index 1 (when present) is the right key.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (reset) begin
        s1[k]  <= 1'b1;
        s2[k]  <= 1'b1;
        deb[k] <= 1'b1;
        cnt[k] <= '0;
      end else begin
        s1[k] <= key_n[k];
        s2[k] <= s1[k];
        if (s2[k] == deb[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == LAST) begin
          deb[k] <= s2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Only the released->pressed flip of the debounced level produces a move.
  always_comb begin
    press = '0;
    for (int k = 0; k < NK; k++) begin
      press[k] = deb[k] & ~s2[k] & (cnt[k] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      L <= 1'b0;
    end else begin
      L <= press[0] & ~freeze;
    end
  end

`ifdef CPU_PLAYER_EN
  logic [9:0] lfsr;
  logic       unused_key_r;

  assign unused_key_r = key_r_n;

  // LFSR free-runs through freeze so the CPU move pattern is not stalled by game-over.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 10'h001;
      R    <= 1'b0;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      R    <= (lfsr[8:0] < cpu_speed) & ~R & ~freeze;
    end
  end
`else
  logic unused_cpu_speed;

  assign unused_cpu_speed = ^cpu_speed;

  always_ff @(posedge clk) begin
    if (reset) begin
      R <= 1'b0;
    end else begin
      R <= press[1] & ~freeze;
    end
  end
`endif

endmodule

// File: tb/tb_tug_input_ctrl.sv
// Directed bench for tug_input_ctrl with DEBOUNCE_CYCLES = 4; CPU checks run only when CPU_PLAYER_EN is defined.
module tb_tug_input_ctrl;

  logic       clk;
  logic       reset;
  logic       key_l_n;
  logic       key_r_n;
  logic       freeze;
  logic [8:0] cpu_speed;
  logic       L;
  logic       R;

  int checks;
  int errors;

  tug_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_l_n  (key_l_n),
    .key_r_n  (key_r_n),
    .freeze   (freeze),
    .cpu_speed(cpu_speed),
    .L        (L),
    .R        (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; key_l_n = 1'b1; key_r_n = 1'b1; freeze = 1'b0; cpu_speed = 9'd0;
    settle(2);
    checks++;
    if (L !== 1'b0) begin errors++; $display("FAIL reset_L got %b want 0", L); end
    checks++;
    if (R !== 1'b0) begin errors++; $display("FAIL reset_R got %b want 0", R); end
    reset = 1'b0;
    settle(4);
  endtask

  // Key low before edge 0, held 20 cycles: single L pulse after edge 5.
  task automatic test_press_hold();
    key_l_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (L !== (i == 5)) begin errors++; $display("FAIL hold_L edge %0d got %b want %b", i, L, (i == 5)); end
      checks++;
      if (R !== 1'b0) begin errors++; $display("FAIL hold_R edge %0d got %b want 0", i, R); end
    end
    key_l_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (L !== 1'b0) begin errors++; $display("FAIL release_L edge %0d got %b want 0", i, L); end
    end
  endtask

  // 3-cycle presses never survive a 4-cycle debounce.
  task automatic test_glitch();
    int pulses;
    for (int b = 0; b < 5; b++) begin
      pulses = 0;
      key_l_n = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); if (L) pulses++; end
      key_l_n = 1'b1;
      for (int i = 0; i < 6; i++) begin tick(); if (L) pulses++; end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL glitch_burst%0d pulses %0d want 0", b, pulses); end
    end
  endtask

  task automatic test_both();
    key_l_n = 1'b0; key_r_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (L !== (i == 5)) begin errors++; $display("FAIL both_L edge %0d got %b want %b", i, L, (i == 5)); end
      checks++;
      if (R !== (i == 5)) begin errors++; $display("FAIL both_R edge %0d got %b want %b", i, R, (i == 5)); end
    end
    key_l_n = 1'b1; key_r_n = 1'b1;
    settle(12);
  endtask

  // Press completed under freeze is dropped; a later fresh press pulses normally.
  task automatic test_freeze();
    int pulses;
    pulses = 0;
    freeze = 1'b1;
    key_r_n = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (R) pulses++; end
    key_r_n = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); if (R) pulses++; end
    freeze = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (R) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL freeze_R pulses %0d want 0", pulses); end
    key_r_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (R !== (i == 5)) begin errors++; $display("FAIL postfreeze_R edge %0d got %b want %b", i, R, (i == 5)); end
    end
    key_r_n = 1'b1;
    settle(12);
  endtask

  // Reset mid-debounce with key still held: one pulse 5 edges after release.
  task automatic test_reset_mid();
    key_l_n = 1'b0;
    settle(3);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (L !== 1'b0) begin errors++; $display("FAIL midreset_L cycle %0d got %b want 0", i, L); end
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (L !== (i == 5)) begin errors++; $display("FAIL afterreset_L edge %0d got %b want %b", i, L, (i == 5)); end
    end
    key_l_n = 1'b1;
    settle(12);
  endtask

`ifdef CPU_PLAYER_EN
  task automatic test_cpu();
    int         pulses;
    logic [9:0] m;
    logic       mr;
    logic       exp_r;
    reset = 1'b1; cpu_speed = 9'd0;
    settle(2);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (R) pulses++; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL cpu_off pulses %0d want 0", pulses); end
    reset = 1'b1; cpu_speed = 9'h1FF;
    settle(2);
    reset = 1'b0;
    m = 10'h001; mr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      key_r_n = i[0];
      tick();
      exp_r = (m[8:0] < 9'h1FF) & ~mr;
      m = {m[8:0], m[9] ^ m[6]};
      mr = exp_r;
      checks++;
      if (R !== exp_r) begin errors++; $display("FAIL cpu_R edge %0d got %b want %b", i, R, exp_r); end
    end
    key_r_n = 1'b1; cpu_speed = 9'd0;
    settle(4);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_press_hold();
    test_glitch();
`ifndef CPU_PLAYER_EN
    test_both();
    test_freeze();
`endif
    test_reset_mid();
`ifdef CPU_PLAYER_EN
    test_cpu();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_input_ctrl.md
# tug_input_ctrl

Player input conditioner for the tug-of-war game: converts the two raw, active-low, bouncing push-buttons into the clean single-cycle `L` / `R` move pulses consumed by the playfield light cells. Sits between the board keys and the light chain, one instance per game. A compile-time option replaces the right-hand human player with an LFSR-driven computer player of adjustable aggressiveness.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a key level change is accepted; legal range 1..65535.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `key_l_n` in 1: raw left-player button, active-low, asynchronous to `clk`.
- `key_r_n` in 1: raw right-player button, active-low, asynchronous; ignored when `CPU_PLAYER_EN` is defined.
- `freeze` in 1: game-over hold from the end-light logic; suppresses all move pulses while high.
- `cpu_speed` in 9: computer-player threshold, unsigned; ignored when `CPU_PLAYER_EN` is undefined.
- `L` out 1: left-player move pulse, exactly one cycle per accepted press.
- `R` out 1: right-player move pulse, exactly one cycle per accepted press or CPU move.

## Operation
- Per human key: two-flop synchronizer (`s1`, `s2`), debounced level `deb`, counter `cnt` of width clog2(DEBOUNCE_CYCLES+1).
- Debounce, each edge: if `s2 == deb`, `cnt <= 0`; else if `cnt == DEBOUNCE_CYCLES-1`, `deb <= s2`, `cnt <= 0`; else `cnt <= cnt+1`.
- Pulse: `L <= (deb flips released→pressed at this edge) & ~freeze`; same for `R`. Release edges never pulse.
- Holding a key produces one pulse only; no auto-repeat.
- `L` and `R` may assert in the same cycle; no arbitration here (the light cells treat simultaneous moves as no move).
- `freeze` blocks pulse outputs only; synchronizers and debouncers keep running. A press completed during `freeze` is lost, not deferred; a key held across `freeze` falling does not pulse.
- Reset: `s1`, `s2`, `deb` = 1 (released); `cnt` = 0; `L` = `R` = 0. A key held through reset yields one pulse after reset release, per normal latency.

## Timing
- Press latency: key sampled low at edge 0 → `s2` low after edge 1 → `deb` flips at edge 1+DEBOUNCE_CYCLES → `L`/`R` high during the cycle following that edge, low after the next edge.
- DEBOUNCE_CYCLES = 4: key low at edge 0, pulse high after edge 5.
- Glitch: any excursion of `s2` lasting fewer than DEBOUNCE_CYCLES cycles leaves `deb` unchanged and produces no pulse.
- Minimum press-to-press spacing for two pulses: 2·DEBOUNCE_CYCLES cycles (press, accepted release, press).
- Reset asserted mid-debounce discards count and any pending pulse at the next edge.

## Configuration
- Macro `CPU_PLAYER_EN`.
- Defined: right-player key path is removed; `key_r_n` ignored. 10-bit Fibonacci LFSR `lfsr`, polynomial x^10+x^7+1: each edge `lfsr <= {lfsr[8:0], lfsr[9]^lfsr[6]}`; reset value 10'h001; advances every cycle including during `freeze`. `R <= (lfsr[8:0] < cpu_speed) & ~R & ~freeze` (unsigned compare on current register) — never high two cycles running. `cpu_speed` = 0 disables the CPU player; larger values move more often.
- Undefined: no LFSR; `R` from debounced `key_r_n` identically to `L`; `cpu_speed` unused but port retained.

## Test plan
- DEBOUNCE_CYCLES=4, reset 2 cycles, drive `key_l_n` low at edge 0 and hold 20 cycles → `L` high exactly one cycle after edge 5, `R` stays 0, no further pulses until release.
- `key_l_n` low for 3 cycles then high, repeated 5 times → `L` never asserts.
- Both keys low at same edge → `L` and `R` high in the same cycle, one cycle wide.
- `freeze`=1, press and release `key_r_n` (held 8 cycles), drop `freeze` → no `R` pulse; next fresh press → one `R` pulse at normal latency.
- Reset asserted 3 cycles into a debounce, key still low, reset released → no pulse during reset; one `L` pulse 5 cycles after release.
- With `CPU_PLAYER_EN`: `cpu_speed`=0 for 200 cycles → `R` always 0; `cpu_speed`=9'h1FF after reset → `R` = 1 after first edge, then alternating 0/1 except where `lfsr[8:0]`=9'h1FF; `key_r_n` toggling has no effect.
